// File: rtl/crc16_engine_if.sv
// crc16_engine_if
//   Groups the crc_* signals that connect seal_register (master) to
//   crc16_engine (slave).
//   crc_init      master->slave  one-cycle pulse: flush FIFO, reload INIT
//   crc_feed      master->slave  one-cycle pulse: enqueue crc_byte
//   crc_byte      master->slave  byte to fold into the CRC
//   crc_busy      slave->master  FIFO non-empty or a byte is still shifting
//   crc_value     slave->master  running CRC register (final when not busy)
//   crc_full      slave->master  FIFO holds FIFO_DEPTH entries
//   crc_count     slave->master  bytes fully processed, mod 256
//   crc_overflow  slave->master  sticky: a feed was dropped on a full FIFO
interface crc16_engine_if;
    logic        crc_init;
    logic        crc_feed;
    logic [7:0]  crc_byte;
    logic        crc_busy;
    logic [15:0] crc_value;
    logic        crc_full;
    logic [7:0]  crc_count;
    logic        crc_overflow;

    modport master (
        output crc_init, crc_feed, crc_byte,
        input  crc_busy, crc_value, crc_full, crc_count, crc_overflow
    );

    modport slave (
        input  crc_init, crc_feed, crc_byte,
        output crc_busy, crc_value, crc_full, crc_count, crc_overflow
    );
endinterface

// File: rtl/crc16_engine.sv
// crc16_engine
//   Bit-serial CRC-16/CCITT-FALSE engine (MSB first, no reflection, no
//   final XOR). Bytes are queued in a small FIFO and folded into the CRC
//   one bit per clock, 8 clocks per byte back-to-back.
//   Ports:
//     clk  - single clock, rising edge
//     rst  - synchronous active-high reset
//     crc  - crc16_engine_if.slave (init/feed/byte in; busy/value/full/
//            count/overflow out)
//   Parameters:
//     POLY       - generator polynomial, normal form
//     INIT       - value loaded by rst and crc_init
//     FIFO_DEPTH - byte queue depth, power of two, >= 2
module crc16_engine #(
    parameter logic [15:0] POLY       = 16'h1021,
    parameter logic [15:0] INIT       = 16'hFFFF,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    crc16_engine_if.slave crc
);
    localparam int              PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [7:0]         r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_fifo_count;

    logic [7:0]         r_sh;
    logic [2:0]         r_bit_cnt;
    logic [15:0]        r_crc;
    logic [7:0]         r_count;
    logic               r_overflow;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_drop;
    logic               w_pop;
    logic               w_shift;
    logic               w_byte_done;

    // One CRC bit step: feedback is the CRC MSB XOR the incoming data bit.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
        logic fb;
        fb = c[15] ^ d;
        return {c[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    endfunction

    assign w_empty = (r_fifo_count == '0);
    assign w_full  = (r_fifo_count == DEPTH_C);

    // Fullness is judged before any same-edge pop. An init empties the FIFO
    // first, so a feed arriving with init is always accepted.
    assign w_push  = crc.crc_feed & (crc.crc_init | ~w_full);
    assign w_drop  = crc.crc_feed & ~crc.crc_init & w_full;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (crc.crc_init) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (!w_empty) w_next_state = S_SHIFT;
                S_SHIFT: if (r_bit_cnt == 3'd7 && w_empty) w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Output / datapath-control logic
    always_comb begin
        w_pop       = 1'b0;
        w_shift     = 1'b0;
        w_byte_done = 1'b0;
        if (!crc.crc_init) begin
            case (r_state)
                S_IDLE: begin
                    w_pop = ~w_empty;
                end
                S_SHIFT: begin
                    w_shift     = 1'b1;
                    w_byte_done = (r_bit_cnt == 3'd7);
                    // Next byte is loaded on the same edge as the last bit.
                    w_pop       = (r_bit_cnt == 3'd7) & ~w_empty;
                end
                default: ;
            endcase
        end
    end

    // Control: FIFO pointers/occupancy, bit counter, byte counter, overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
            r_bit_cnt    <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
        end else if (crc.crc_init) begin
            // Flush by catching the read pointer up; a same-edge feed is
            // written at the old write pointer, i.e. the new head.
            r_rd_ptr     <= r_wr_ptr;
            r_wr_ptr     <= r_wr_ptr + PTR_W'(w_push);
            r_fifo_count <= (PTR_W + 1)'(w_push);
            r_bit_cnt    <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + (PTR_W + 1)'(1);
                2'b01:   r_fifo_count <= r_fifo_count - (PTR_W + 1)'(1);
                default: r_fifo_count <= r_fifo_count;
            endcase
            if (w_pop) begin
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_byte_done) r_count <= r_count + 8'd1;
            if (w_drop)      r_overflow <= 1'b1;
        end
    end

    // CRC register: architecturally visible, so it is reloaded on rst/init
    always_ff @(posedge clk) begin
        if (rst || crc.crc_init) begin
            r_crc <= INIT;
        end else if (w_shift) begin
            r_crc <= crc_step(r_crc, r_sh[7]);
        end
    end

    // Data: FIFO storage and shift register carry no reset
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= crc.crc_byte;
        if (w_pop) begin
            r_sh <= r_fifo[r_rd_ptr];
        end else if (w_shift) begin
            r_sh <= {r_sh[6:0], 1'b0};
        end
    end

    assign crc.crc_busy     = (r_state == S_SHIFT) | ~w_empty;
    assign crc.crc_full     = w_full;
    assign crc.crc_value    = r_crc;
    assign crc.crc_count    = r_count;
    assign crc.crc_overflow = r_overflow;

endmodule

// File: tb/tb_crc16_engine.sv
module tb_crc16_engine;
    localparam logic [15:0] INIT_V = 16'hFFFF;
    localparam logic [15:0] POLY_V = 16'h1021;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    crc16_engine_if bus ();

    crc16_engine #(
        .POLY       (POLY_V),
        .INIT       (INIT_V),
        .FIFO_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .crc (bus)
    );

    typedef struct packed {
        logic [79:0] msg;
        logic [3:0]  len;
        logic        paced;
        logic [15:0] exp_crc;
    } vec_t;

    typedef struct {
        logic [15:0] crc;
        logic [7:0]  cnt;
        int          exp_edge;
    } sb_t;

    sb_t         sb [$];
    vec_t        vecs [5];
    int          n_vec = 0;
    int          n_err = 0;
    int          edge_n = 0;
    logic [15:0] crc_m;
    logic [7:0]  cnt_m;
    logic [7:0]  prev_cnt = 8'd0;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic logic [15:0] crc_byte_m(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ POLY_V) : (r << 1);
        return r;
    endfunction

    function automatic logic [7:0] msg_byte(input vec_t v, input int k);
        return v.msg[8*(int'(v.len) - k) - 1 -: 8];
    endfunction

    function automatic logic [15:0] crc_msg(input vec_t v);
        logic [15:0] c;
        c = INIT_V;
        for (int k = 0; k < int'(v.len); k++) c = crc_byte_m(c, msg_byte(v, k));
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: each byte completion pops the next expectation.
    always @(negedge clk) begin
        if (rst) begin
            prev_cnt <= 8'd0;
        end else begin
            if (bus.crc_count == prev_cnt + 8'd1) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: count %0d, expected no completion", bus.crc_count);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check("crc_at_done", {16'h0, bus.crc_value}, {16'h0, e.crc});
                    check("count_at_done", {24'h0, bus.crc_count}, {24'h0, e.cnt});
                    if (e.exp_edge >= 0) check("done_edge", edge_n, e.exp_edge);
                end
            end
            prev_cnt <= bus.crc_count;
        end
    end

    task automatic model_push(input logic [7:0] b, input int exp_edge);
        crc_m = crc_byte_m(crc_m, b);
        cnt_m = cnt_m + 8'd1;
        sb.push_back('{crc: crc_m, cnt: cnt_m, exp_edge: exp_edge});
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (bus.crc_busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (bus.crc_busy) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: crc_busy 1, expected 0", name);
        end
    endtask

    task automatic do_init(input bit with_feed, input logic [7:0] b);
        sb.delete();
        crc_m = INIT_V;
        cnt_m = 8'd0;
        bus.crc_init = 1'b1;
        bus.crc_feed = with_feed;
        bus.crc_byte = b;
        @(negedge clk);
        bus.crc_init = 1'b0;
        bus.crc_feed = 1'b0;
        if (with_feed) model_push(b, edge_n + 9);
    endtask

    task automatic feed_paced(input logic [7:0] b);
        wait_idle("paced");
        bus.crc_feed = 1'b1;
        bus.crc_byte = b;
        @(negedge clk);
        bus.crc_feed = 1'b0;
        model_push(b, edge_n + 9);
        check("busy_after_feed", {31'h0, bus.crc_busy}, 32'd1);
    endtask

    // Back-to-back feeds, holding off only while the FIFO is full.
    task automatic feed_burst(input vec_t v);
        int first;
        first = -1;
        for (int k = 0; k < int'(v.len); k++) begin
            int t;
            t = 0;
            while (bus.crc_full && t < 100) begin
                bus.crc_feed = 1'b0;
                @(negedge clk);
                t++;
            end
            if (bus.crc_full) begin
                n_vec++;
                n_err++;
                $display("FAIL burst_full_timeout: crc_full 1, expected 0");
            end
            bus.crc_feed = 1'b1;
            bus.crc_byte = msg_byte(v, k);
            if (first < 0) first = edge_n + 1;
            model_push(msg_byte(v, k), first + 9 + 8 * k);
            @(negedge clk);
        end
        bus.crc_feed = 1'b0;
    endtask

    task automatic feed_msg(input vec_t v, input int from);
        if (v.paced) begin
            for (int k = from; k < int'(v.len); k++) feed_paced(msg_byte(v, k));
        end else begin
            feed_burst(v);
        end
    endtask

    task automatic finish_check(input string name, input logic [15:0] exp_crc,
                                input logic [7:0] exp_cnt, input logic exp_ovf);
        wait_idle(name);
        @(negedge clk);
        check({name, "_crc"}, {16'h0, bus.crc_value}, {16'h0, exp_crc});
        check({name, "_count"}, {24'h0, bus.crc_count}, {24'h0, exp_cnt});
        check({name, "_overflow"}, {31'h0, bus.crc_overflow}, {31'h0, exp_ovf});
        check({name, "_pending"}, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bus.crc_init = 1'b0;
        bus.crc_feed = 1'b0;
        bus.crc_byte = 8'h00;
        crc_m = INIT_V;
        cnt_m = 8'd0;

        vecs[0] = '{msg: 80'("123456789"),  len: 4'd9,  paced: 1'b1, exp_crc: 16'h29B1};
        vecs[1] = '{msg: 80'("123456789"),  len: 4'd9,  paced: 1'b0, exp_crc: 16'h29B1};
        vecs[2] = '{msg: 80'("A"),          len: 4'd1,  paced: 1'b1, exp_crc: 16'h0000};
        vecs[3] = '{msg: 80'("Hello, CRC"), len: 4'd10, paced: 1'b0, exp_crc: 16'h0000};
        vecs[4] = '{msg: 80'("~~~~~~"),     len: 4'd6,  paced: 1'b0, exp_crc: 16'h0000};
        for (int i = 2; i < 5; i++) vecs[i].exp_crc = crc_msg(vecs[i]);

        // Reset defaults
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_value", {16'h0, bus.crc_value}, {16'h0, INIT_V});
        check("rst_busy", {31'h0, bus.crc_busy}, 32'd0);
        check("rst_full", {31'h0, bus.crc_full}, 32'd0);
        check("rst_count", {24'h0, bus.crc_count}, 32'd0);
        check("rst_overflow", {31'h0, bus.crc_overflow}, 32'd0);

        // Table-driven messages
        for (int i = 0; i < 5; i++) begin
            do_init(1'b0, 8'h00);
            check("init_value", {16'h0, bus.crc_value}, {16'h0, INIT_V});
            check("init_busy", {31'h0, bus.crc_busy}, 32'd0);
            feed_msg(vecs[i], 0);
            finish_check("vec", vecs[i].exp_crc, {4'h0, vecs[i].len}, 1'b0);
        end

        // Overflow: six consecutive feeds into a depth-4 FIFO
        do_init(1'b0, 8'h00);
        begin
            int first;
            first = edge_n + 1;
            for (int k = 0; k < 6; k++) begin
                bus.crc_feed = 1'b1;
                bus.crc_byte = 8'hC0 + 8'(k);
                if (k < 5) model_push(8'hC0 + 8'(k), first + 9 + 8 * k);
                if (k == 5) check("full_after_5", {31'h0, bus.crc_full}, 32'd1);
                @(negedge clk);
            end
            bus.crc_feed = 1'b0;
        end
        finish_check("ovf", crc_m, 8'd5, 1'b1);

        // Init mid-byte, with a same-edge feed
        do_init(1'b0, 8'h00);
        feed_paced(8'hA5);
        repeat (2) @(negedge clk);
        do_init(1'b1, msg_byte(vecs[0], 0));
        v = vecs[0];
        for (int k = 1; k < 9; k++) feed_paced(msg_byte(v, k));
        finish_check("init_mid", 16'h29B1, 8'd9, 1'b0);

        // Reset mid-burst with 3 bytes queued
        do_init(1'b0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            bus.crc_feed = 1'b1;
            bus.crc_byte = 8'h58 + 8'(k);
            @(negedge clk);
        end
        bus.crc_feed = 1'b0;
        rst = 1'b1;
        sb.delete();
        crc_m = INIT_V;
        cnt_m = 8'd0;
        @(negedge clk);
        check("rstmid_busy", {31'h0, bus.crc_busy}, 32'd0);
        check("rstmid_value", {16'h0, bus.crc_value}, {16'h0, INIT_V});
        rst = 1'b0;
        feed_msg(vecs[0], 0);
        finish_check("rst_mid", 16'h29B1, 8'd9, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/crc16_engine.md
# crc16_engine

Bit-serial CRC-16 engine that sits directly below `seal_register` on its `crc_*` port group. It takes bytes from the seal sequencer through a small input FIFO and folds them into a running CRC-16/CCITT-FALSE value, one bit per clock. `crc_value` is final whenever `crc_busy` is low. A byte counter and a sticky overflow flag are kept for the bench and for debug MMIO.

## Interface
Parameters:
- `POLY`, default 16'h1021: generator polynomial, normal (non-reflected) form.
- `INIT`, default 16'hFFFF: value loaded by reset and by `crc_init`.
- `FIFO_DEPTH`, default 4: input byte queue depth; must be a power of two, minimum 2.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `crc_init`  in  1: one-cycle pulse. Flushes the FIFO, aborts any byte in progress and reloads `INIT`.
- `crc_feed`  in  1: one-cycle pulse; enqueues `crc_byte`.
- `crc_byte`  in  8: byte to fold in; sampled only when `crc_feed` is 1.
- `crc_busy`  out  1: 1 while the FIFO is non-empty or a byte is still shifting.
- `crc_value`  out  16: running CRC register; only meaningful when `crc_busy` is 0.
- `crc_full`  out  1: FIFO holds `FIFO_DEPTH` entries.
- `crc_count`  out  8: bytes fully processed since the last init or reset, mod 256.
- `crc_overflow`  out  1: sticky; set when a feed is dropped because the FIFO was full.

## Operation
- **Reset values.** On `rst` at an edge: `crc_value`=`INIT`, FIFO empty, shifter idle, bit counter=0, `crc_count`=0, `crc_overflow`=0. The outputs therefore read `crc_busy`=0 and `crc_full`=0.
- **States.** Two states, IDLE and SHIFT.
  - IDLE → SHIFT: at an edge where the FIFO is non-empty. The head byte is popped into an 8-bit shift register and the bit counter is cleared.
  - SHIFT: one bit per edge, MSB first. The update is `fb = crc[15] ^ sh[7]`, then `crc = {crc[14:0],1'b0} ^ (fb ? POLY : 0)`, then `sh <<= 1`.
  - End of a byte (8th bit edge): `crc_count` increments. If the FIFO is non-empty, the next byte is popped on that same edge and the state stays SHIFT (back-to-back, 8 clocks per byte). Otherwise the state goes to IDLE.
- **`crc_busy`** is combinational: `(state==SHIFT) | (fifo_count!=0)`.
- **`crc_full`** is combinational: `fifo_count==FIFO_DEPTH`.
- **Feed handling.**
  - If `crc_feed` is high and the FIFO is not full, the byte is written.
  - If `crc_feed` is high and the FIFO is full, the byte is dropped and `crc_overflow` is set. This holds even when a pop occurs on the same edge: fullness is judged before the pop.
  - A push and a pop on the same edge leave `fifo_count` unchanged.
- **Init handling.** `crc_init` takes priority over everything except `rst`:
  - FIFO flushed, state goes to IDLE, `crc_value`=`INIT`, `crc_count`=0, `crc_overflow`=0.
  - If `crc_feed` is high on the same edge, its byte is written into the freshly emptied FIFO and is not dropped.
- **Width rules.**
  - FIFO pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally.
  - `fifo_count` is one bit wider than the pointers.
  - `crc_count` wraps from 255 to 0 with no flag.
- **No output reflection or final XOR.** `crc_value` is the raw register. This matches what `seal_register` latches into the sealed record.

## Timing
- Feed sampled at edge N with the engine idle and the FIFO empty:
  - `crc_busy`=1 from cycle N+1.
  - Pop and load at edge N+1.
  - Bits processed at edges N+2…N+9.
  - `crc_busy`=0 and the final `crc_value` are visible in the cycle after edge N+9. Latency is 9 clocks.
- Sustained throughput is 1 byte per 8 clocks, provided the FIFO is kept non-empty.
- The `seal_register` handshake (feed, then wait for `crc_busy` low) is always legal. `crc_busy` is high in the cycle right after any accepted feed, so a waiter can never sample a stale low.
- `crc_init` at edge M: `crc_value`=`INIT` and `crc_busy`=0 in cycle M+1, unless `crc_feed` was also high at edge M.
- `rst` or `crc_init` in the middle of a byte discards the partial byte. That byte is not counted.

## Test plan
- **Reset defaults.** Hold `rst` 3 cycles, then release → `crc_value`=16'hFFFF, `crc_busy`=0, `crc_full`=0, `crc_count`=0, `crc_overflow`=0.
- **Check string, handshake paced.** `crc_init`, then feed ASCII "123456789", waiting for `crc_busy`=0 before each feed → final `crc_value`=16'h29B1, `crc_count`=9. Also check that `crc_busy` rises in the cycle after each feed and that each byte completes 9 cycles after its feed edge.
- **Check string, burst.** Feed "1234" on 4 consecutive cycles, then pace "56789" whenever `crc_full`=0 → `crc_value`=16'h29B1, `crc_count`=9, `crc_overflow`=0. The gap between byte completions is exactly 8 cycles while the FIFO is non-empty.
- **Overflow.** `crc_init`, then feed on 6 consecutive cycles → `crc_full`=1 after the 5th feed edge and the 6th byte is dropped. Once idle: `crc_overflow`=1, `crc_count`=5, `crc_value` equals the golden-model CRC of the first 5 bytes.
- **Init mid-byte.** Feed 0xA5; 3 cycles later pulse `crc_init` together with `crc_feed` of "1", then feed "23456789" → final `crc_value`=16'h29B1, `crc_count`=9, `crc_overflow`=0.
- **Reset mid-burst.** Assert `rst` while 3 bytes are queued → next cycle `crc_busy`=0 and `crc_value`=16'hFFFF. A subsequent "123456789" gives 16'h29B1.
